// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default sizing for program_loader.
package loader_pkg;
   typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORDS_DEFAULT = 32;
   localparam int ADDR_W_DEFAULT = 5;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: shifts bytes MSB-first into a 32-bit word and flags the 4th byte of each word.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        take,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_ready
);
   logic [1:0] count;
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         word_out <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (take) begin
         count <= count + 2'd1;
         word_out <= {word_out[23:0], byte_in};
      end
   end
   assign word_ready = take && count == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a byte image into instruction RAM and the packed code image.
// Optional trailing checksum byte enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import loader_pkg::*;
#(
   parameter int WORDS = WORDS_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [31:0]           mem_data,
   output logic                  mem_we,
   output logic [32*WORDS-1:0]   code,
   output logic                  busy,
   output logic                  load_done,
   output logic                  error
);
   state_t state, next;
   logic [ADDR_W-1:0] idx;
   logic [31:0] word;
   logic word_ready, launch, last, take;
   assign launch = start && (state == IDLE || state == DONE);
   assign last = idx == ADDR_W'(WORDS - 1);
   assign take = byte_valid && byte_ready;
   byte_packer packer (
      .clk(clk),
      .reset(reset),
      .clear(launch),
      .take(byte_valid && state == COLLECT),
      .byte_in(byte_in),
      .word_out(word),
      .word_ready(word_ready)
   );
   always_ff @(posedge clk) state <= reset ? IDLE : next;
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE: next = start ? COLLECT : state;
         COLLECT:    next = word_ready ? WRITE : COLLECT;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         WRITE:      next = last ? CHECK : COLLECT;
         CHECK:      next = take ? DONE : CHECK;
`else
         WRITE:      next = last ? DONE : COLLECT;
`endif
         default:    next = IDLE;
      endcase
   end
   always_comb begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      byte_ready = state == COLLECT || state == CHECK;
`else
      byte_ready = state == COLLECT;
`endif
      busy = state == COLLECT || state == WRITE || state == CHECK;
      load_done = state == DONE;
      mem_we = state == WRITE;
      mem_addr = idx;
      mem_data = word;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
         code <= '0;
      end else if (launch) begin
         idx <= '0;
         code <= '0;
      end else if (state == WRITE) begin
         code[32*int'(idx) +: 32] <= word;
         if (!last) idx <= idx + 1'b1;
      end
   end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   always_ff @(posedge clk) begin
      if (reset) begin
         sum <= '0;
         error <= 1'b0;
      end else if (launch) begin
         sum <= '0;
         error <= 1'b0;
      end else if (take) begin
         sum <= sum + byte_in;
         if (state == CHECK) error <= (sum + byte_in) != 8'd0;
      end
   end
`else
   assign error = 1'b0;
`endif
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Producer end of the computer's program-image interface.
- Accepts the program as a handshaked byte stream, most significant byte first.
- Assembles 32-bit words and writes each one to instruction RAM through a single write port.
- Maintains the packed `code` image that `computer` consumes, and signals completion so the computer can be released from its hold.

Parameters:
- WORDS, 32, number of 32-bit program words per load; `code` width is 32*WORDS (1024 at default).
- ADDR_W, 5, RAM word-address width; must satisfy 2**ADDR_W >= WORDS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse to begin a load.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_W  RAM word address.
- mem_data  out  32  RAM write data.
- mem_we  out  1  RAM write enable, one-cycle pulse per word.
- code  out  32*WORDS  packed image; word k occupies code[32k+31:32k].
- busy  out  1  load in progress.
- load_done  out  1  image complete; held high.
- error  out  1  checksum mismatch (CHECKSUM_EN only; otherwise constant 0).

Behaviour:
- Reset (synchronous, active-high): state = IDLE. All outputs 0, `code` cleared to 0, byte counter 0, word index 0. A reset in any state, including mid-word, aborts the load and discards any partial word.
- States: IDLE, COLLECT, WRITE, CHECK (feature only), DONE.
- IDLE:
  - byte_ready = 0, busy = 0.
  - On start = 1: clear `code`, word index and error; go to COLLECT.
- COLLECT:
  - byte_ready = 1, busy = 1.
  - A byte transfers when byte_valid && byte_ready. The byte is shifted into the word register: word = {word[23:0], byte_in}.
  - byte_ready is registered (state-derived) and does not depend combinationally on byte_valid.
  - After the 4th byte transfers, go to WRITE. byte_ready is 0 in WRITE.
  - byte_valid low stalls the load indefinitely, with no timeout.
- WRITE (exactly one cycle):
  - mem_we = 1, mem_addr = word index, mem_data = assembled word.
  - The same word is written into the matching `code` slice at the end of the cycle.
  - If word index == WORDS-1, go to CHECK (feature on) or DONE. Otherwise increment the index and return to COLLECT.
- DONE:
  - load_done = 1, busy = 0.
  - `code` is held stable until the next start.
  - start in DONE clears load_done and begins a new load in the following cycle, entering COLLECT.
- start while busy is ignored.
- Bytes presented while byte_ready = 0 are not consumed; the source must hold them.
- Latency with byte_valid held high:
  - start at cycle t → first byte accepted at t+1.
  - WRITE for word k at t+5(k+1).
  - load_done rises at t+5·WORDS+1, which is t+161 at default.
- mem_addr, mem_data and mem_we are registered outputs. mem_addr and mem_data may hold stale values whenever mem_we = 0.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last WRITE, go to CHECK with byte_ready = 1 and accept one further byte.
  - The 8-bit modulo-256 sum of all 4·WORDS data bytes plus this byte must equal 0x00.
  - On mismatch, error = 1. Go to DONE in either case.
  - error holds until the next start or reset.
  - Latency: one extra accepted byte before DONE.
- Without the macro: no CHECK state, error tied to 0, no extra byte consumed.

Decomposition:
- Shared package `loader_pkg`:
  - state encoding constants: IDLE, COLLECT, WRITE, CHECK, DONE.
  - BYTES_PER_WORD = 4.
  - default WORDS and ADDR_W.
- One sub-module: `byte_packer`, a 4-byte shift register with a byte counter that pulses word_ready and presents word_out.
- The FSM, RAM port and `code` image stay in program_loader.

Test Plan:
- Reset, then start, then stream bytes 09 12 38 98 with valid held high → WRITE cycle shows mem_we = 1, mem_addr = 0, mem_data = 0x09123898, and code[31:0] = 0x09123898 on the following cycle.
- Stream 128 bytes of six repeating words 0x09123898, 0x109adf12, 0x21439802, 0xda129586, 0x01892fe7, 0x04792930 with valid held high → exactly 32 mem_we pulses at addresses 0..31, load_done rises exactly 161 cycles after start, and code[63:32] = 0x109adf12.
- Toggle byte_valid low for 3 cycles on every other byte → same final `code` image and same write count; load_done is delayed by exactly the stall cycles.
- Assert reset after 2 bytes of word 5 → on the next cycle busy = 0, code = 0, mem_we = 0. Restart → the first write lands at address 0.
- Assert start during COLLECT and again in DONE → the first has no effect; the second drops load_done and starts a new load in the next cycle.
- With PROGRAM_LOADER_CHECKSUM_EN: a correct trailing checksum byte gives load_done = 1, error = 0; the same byte +1 gives load_done = 1, error = 1. Without the macro, error stays 0 and byte_ready = 0 after the last WRITE.
